// File: rtl/rv_core_pkg.sv
// rv_core_pkg
// Shared core definitions: datapath width, PC increment, EX/MEM FSM state
// encoding and the EX/MEM pipeline-register payload layout.
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    // EX/MEM redirect FSM. SHADOW is the cycle in which oRedirect is high;
    // whatever the execute stage presents then came from the wrong path.
    typedef enum logic {
        NORMAL = 1'b0,
        SHADOW = 1'b1
    } exmem_state_t;

    // EX/MEM stage register contents.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd_addr;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } exmem_payload_t;

    localparam exmem_payload_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/branch_target_unit.sv
// branch_target_unit
// Purely combinational control-flow resolution for the executing instruction.
//   pc, imm          : instruction PC and sign-extended immediate
//   alu_result       : ALU output (rs1+imm for JALR)
//   alu_zero         : branch-condition-true flag for branch instructions
//   is_branch/jal/jalr : instruction class (one-hot or none)
//   taken            : control transfer happens
//   target           : transfer target (32-bit wrap-around arithmetic)
//   misalign         : taken and target not 4-byte aligned (bit 1 set)
module branch_target_unit
    import rv_core_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    always_comb begin
        taken = is_jal || is_jalr || (is_branch && alu_zero);
        // JALR clears bit 0 of rs1+imm; everything else is PC-relative.
        if (is_jalr)
            target = {alu_result[XLEN-1:1], 1'b0};
        else
            target = pc + imm;
        // Bit 0 is always clear here, so only bit 1 can misalign.
        misalign = taken && target[1];
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register with control-flow redirect, misaligned-target
// exception reporting, wrong-path squash and branch performance counters.
// Ports:
//   iClk, iRst                 : clock, synchronous active-high reset
//   iValid ... iIsJalr         : execute-stage instruction and control
//   iStall                     : memory stage not ready, hold everything
//   oReady                     : !iStall
//   oValid ... oMemWrite       : registered EX/MEM payload
//   oRedirect, oRedirectPc     : one-cycle PC redirect pulse and target
//   oExcMisalign, oExcPc       : one-cycle misaligned-target exception
//   oBranchCnt, oTakenCnt      : conditional-branch / taken-branch counters
module ex_mem_stage
    import rv_core_pkg::*;
(
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iImm,
    input  logic [XLEN-1:0] iAluResult,
    input  logic            iAluZero,
    input  logic [XLEN-1:0] iRs2Data,
    input  logic [4:0]      iRdAddr,
    input  logic            iRegWrite,
    input  logic            iMemRead,
    input  logic            iMemWrite,
    input  logic            iIsBranch,
    input  logic            iIsJal,
    input  logic            iIsJalr,
    input  logic            iStall,
    output logic            oReady,
    output logic            oValid,
    output logic [XLEN-1:0] oResult,
    output logic [XLEN-1:0] oStoreData,
    output logic [4:0]      oRdAddr,
    output logic            oRegWrite,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic            oRedirect,
    output logic [XLEN-1:0] oRedirectPc,
    output logic            oExcMisalign,
    output logic [XLEN-1:0] oExcPc,
    output logic [XLEN-1:0] oBranchCnt,
    output logic [XLEN-1:0] oTakenCnt
);

    exmem_state_t   state;
    exmem_payload_t payload;
    logic           redirect;
    logic [XLEN-1:0] redirect_pc;
    logic           exc_misalign;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] branch_cnt;
    logic [XLEN-1:0] taken_cnt;

    logic            taken;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            accept;
    logic            do_redirect;
    exmem_payload_t  next_payload;

    branch_target_unit u_btu (
        .pc        (iPc),
        .imm       (iImm),
        .alu_result(iAluResult),
        .alu_zero  (iAluZero),
        .is_branch (iIsBranch),
        .is_jal    (iIsJal),
        .is_jalr   (iIsJalr),
        .taken     (taken),
        .target    (target),
        .misalign  (misalign)
    );

    // Instructions arriving in SHADOW are wrong-path and never accepted.
    assign accept      = iValid && !iStall && (state == NORMAL);
    assign do_redirect = accept && taken && !misalign;

    always_comb begin
        next_payload = EXMEM_BUBBLE;
        if (accept) begin
            next_payload.valid      = 1'b1;
            next_payload.result     = (iIsJal || iIsJalr) ? (iPc + PC_INC) : iAluResult;
            next_payload.store_data = iRs2Data;
            next_payload.rd_addr    = iRdAddr;
            // A faulting jump/branch must have no architectural side effects.
            next_payload.reg_write  = iRegWrite && !misalign;
            next_payload.mem_read   = iMemRead  && !misalign;
            next_payload.mem_write  = iMemWrite && !misalign;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= NORMAL;
            payload      <= EXMEM_BUBBLE;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            exc_misalign <= 1'b0;
            exc_pc       <= '0;
            branch_cnt   <= '0;
            taken_cnt    <= '0;
        end else begin
            // Pulses are driven only by an accept; a stall can never create
            // an accept, so they cannot be stretched or repeated.
            redirect     <= do_redirect;
            exc_misalign <= accept && misalign;
            if (do_redirect)
                redirect_pc <= target;
            if (accept && misalign)
                exc_pc <= iPc;

            case (state)
                NORMAL:  if (do_redirect) state <= SHADOW;
                SHADOW:  state <= NORMAL;
                default: state <= NORMAL;
            endcase

            if (!iStall)
                payload <= next_payload;

            if (accept && iIsBranch) begin
                branch_cnt <= branch_cnt + 1'b1;
                if (taken)
                    taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

    assign oReady       = !iStall;
    assign oValid       = payload.valid;
    assign oResult      = payload.result;
    assign oStoreData   = payload.store_data;
    assign oRdAddr      = payload.rd_addr;
    assign oRegWrite    = payload.reg_write;
    assign oMemRead     = payload.mem_read;
    assign oMemWrite    = payload.mem_write;
    assign oRedirect    = redirect;
    assign oRedirectPc  = redirect_pc;
    assign oExcMisalign = exc_misalign;
    assign oExcPc       = exc_pc;
    assign oBranchCnt   = branch_cnt;
    assign oTakenCnt    = taken_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Directed scenarios followed by random traffic, every cycle compared
// against a behavioural model of the EX/MEM stage.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, valid, zero, rw, mr, mw, br, jal, jalr, stall;
    logic [31:0] pc, imm, alu, rs2;
    logic [4:0]  rd;

    logic        o_ready, o_valid, o_rw, o_mr, o_mw, o_redir, o_exc;
    logic [31:0] o_result, o_store, o_rpc, o_epc, o_bcnt, o_tcnt;
    logic [4:0]  o_rd;

    // model state
    logic        m_valid, m_rw, m_mr, m_mw, m_redir, m_exc, m_shadow;
    logic [31:0] m_result, m_store, m_rpc, m_epc, m_bcnt, m_tcnt;
    logic [4:0]  m_rd;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .iClk(clk), .iRst(rst), .iValid(valid), .iPc(pc), .iImm(imm),
        .iAluResult(alu), .iAluZero(zero), .iRs2Data(rs2), .iRdAddr(rd),
        .iRegWrite(rw), .iMemRead(mr), .iMemWrite(mw),
        .iIsBranch(br), .iIsJal(jal), .iIsJalr(jalr), .iStall(stall),
        .oReady(o_ready), .oValid(o_valid), .oResult(o_result),
        .oStoreData(o_store), .oRdAddr(o_rd), .oRegWrite(o_rw),
        .oMemRead(o_mr), .oMemWrite(o_mw), .oRedirect(o_redir),
        .oRedirectPc(o_rpc), .oExcMisalign(o_exc), .oExcPc(o_epc),
        .oBranchCnt(o_bcnt), .oTakenCnt(o_tcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, " valid"},  {31'd0, o_valid}, {31'd0, m_valid});
        chk({step, " result"}, o_result, m_result);
        chk({step, " store"},  o_store,  m_store);
        chk({step, " rd"},     {27'd0, o_rd}, {27'd0, m_rd});
        chk({step, " ctrl"},   {29'd0, o_rw, o_mr, o_mw}, {29'd0, m_rw, m_mr, m_mw});
        chk({step, " redir"},  {31'd0, o_redir}, {31'd0, m_redir});
        chk({step, " rpc"},    o_rpc, m_rpc);
        chk({step, " exc"},    {31'd0, o_exc}, {31'd0, m_exc});
        chk({step, " epc"},    o_epc, m_epc);
        chk({step, " bcnt"},   o_bcnt, m_bcnt);
        chk({step, " tcnt"},   o_tcnt, m_tcnt);
    endtask

    // Next architectural outputs from the current inputs, following the
    // stage's rules directly.
    task automatic model_step();
        logic        tk, mis, acc;
        logic [31:0] tgt;
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_redir, m_exc, m_shadow} = '0;
            {m_result, m_store, m_rpc, m_epc, m_bcnt, m_tcnt} = '0;
            m_rd = '0;
            return;
        end
        tk  = jal || jalr || (br && zero);
        tgt = jalr ? (alu & 32'hFFFF_FFFE) : pc + imm;
        mis = tk && ((tgt & 32'd2) != 0);
        acc = valid && !stall && !m_shadow;
        m_redir  = acc && tk && !mis;
        m_exc    = acc && mis;
        m_shadow = m_redir;
        if (m_redir) m_rpc = tgt;
        if (m_exc)   m_epc = pc;
        if (!stall) begin
            m_valid  = acc;
            m_result = !acc ? 32'd0 : (jal || jalr) ? pc + 32'd4 : alu;
            m_store  = acc ? rs2 : 32'd0;
            m_rd     = acc ? rd : 5'd0;
            m_rw     = acc && rw && !mis;
            m_mr     = acc && mr && !mis;
            m_mw     = acc && mw && !mis;
        end
        if (acc && br) begin
            m_bcnt = m_bcnt + 1;
            if (tk) m_tcnt = m_tcnt + 1;
        end
    endtask

    // One clock: check oReady, advance DUT and model, compare at negedge.
    task automatic cycle(input string step);
        #1;
        chk({step, " ready"}, {31'd0, o_ready}, {31'd0, !stall});
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(step);
    endtask

    task automatic idle();
        rst = 0; valid = 0; zero = 0; rw = 0; mr = 0; mw = 0;
        br = 0; jal = 0; jalr = 0; stall = 0;
        pc = 0; imm = 0; alu = 0; rs2 = 0; rd = 0;
    endtask

    task automatic randomize_inputs();
        int cls;
        rst   = ($urandom_range(63) == 0);
        valid = ($urandom_range(3) != 0);
        stall = ($urandom_range(3) == 0);
        pc    = $urandom & 32'hFFFF_FFFC;
        imm   = $urandom;
        alu   = $urandom;
        rs2   = $urandom;
        rd    = 5'($urandom);
        zero  = 1'($urandom);
        rw    = 1'($urandom);
        mr    = 1'($urandom);
        mw    = 1'($urandom);
        cls   = $urandom_range(4);
        br    = (cls == 1) || (cls == 4);
        jal   = (cls == 2);
        jalr  = (cls == 3);
    endtask

    initial begin
        idle();
        {m_valid, m_rw, m_mr, m_mw, m_redir, m_exc, m_shadow} = '0;
        {m_result, m_store, m_rpc, m_epc, m_bcnt, m_tcnt} = '0;
        m_rd = '0;

        // Reset, with a taken branch and stall presented to show reset wins.
        @(negedge clk);
        rst = 1; valid = 1; br = 1; zero = 1; stall = 1; pc = 32'h10; imm = 32'h8;
        cycle("reset");
        cycle("reset2");
        idle();

        // BEQ taken
        valid = 1; br = 1; zero = 1; pc = 32'h100; imm = 32'h20; rw = 0;
        cycle("beq");
        chk("beq redirect", {31'd0, o_redir}, 32'd1);
        chk("beq target", o_rpc, 32'h120);
        chk("beq bcnt", o_bcnt, 32'd1);
        chk("beq tcnt", o_tcnt, 32'd1);

        // Wrong-path instruction in the redirect cycle
        idle(); valid = 1; rw = 1; rd = 5'd7; alu = 32'h55;
        cycle("shadow");
        chk("shadow valid", {31'd0, o_valid}, 32'd0);
        chk("shadow regwrite", {31'd0, o_rw}, 32'd0);
        chk("shadow redirect", {31'd0, o_redir}, 32'd0);

        // JALR to a misaligned target
        idle(); valid = 1; jalr = 1; alu = 32'h203; pc = 32'h40; rw = 1; rd = 5'd3;
        cycle("jalr_mis");
        chk("jalr exc", {31'd0, o_exc}, 32'd1);
        chk("jalr epc", o_epc, 32'h40);
        chk("jalr redirect", {31'd0, o_redir}, 32'd0);
        chk("jalr regwrite", {31'd0, o_rw}, 32'd0);
        chk("jalr valid", {31'd0, o_valid}, 32'd1);

        // Exception pulse lasts one cycle; no shadow after misalign
        idle(); valid = 1; rw = 1; rd = 5'd4; alu = 32'h99;
        cycle("post_exc");
        chk("post_exc pulse", {31'd0, o_exc}, 32'd0);
        chk("post_exc captured", {31'd0, o_valid}, 32'd1);

        // JAL link value and target
        idle(); valid = 1; jal = 1; pc = 32'h80; imm = 32'h10; rd = 5'd1; rw = 1;
        cycle("jal");
        chk("jal link", o_result, 32'h84);
        chk("jal target", o_rpc, 32'h90);

        // Stall for three cycles with changing inputs (first one is shadow).
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(); rst = 0; stall = 1; valid = 1; br = 1; zero = 1;
            jal = 0; jalr = 0;
            cycle("stall");
            chk("stall ready", {31'd0, o_ready}, 32'd0);
        end
        chk("stall bcnt held", o_bcnt, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle("rand");
        end

        // Counter wrap: preload both counters to all-ones
        idle(); rst = 1; cycle("pre_wrap_rst"); idle();
        force dut.branch_cnt = 32'hFFFF_FFFF;
        force dut.taken_cnt  = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        release dut.taken_cnt;
        m_bcnt = 32'hFFFF_FFFF; m_tcnt = 32'hFFFF_FFFF;
        valid = 1; br = 1; zero = 1; pc = 32'h200; imm = 32'h40;
        cycle("wrap");
        chk("wrap bcnt", o_bcnt, 32'd0);
        chk("wrap tcnt", o_tcnt, 32'd0);

        // Reset asserted in the redirect cycle, with another taken branch
        idle(); cycle("wrap_shadow");
        valid = 1; br = 1; zero = 1; pc = 32'h300; imm = 32'h100;
        cycle("pre_rst");
        chk("pre_rst redirect", {31'd0, o_redir}, 32'd1);
        rst = 1;
        cycle("mid_rst");
        chk("mid_rst redirect", {31'd0, o_redir}, 32'd0);
        chk("mid_rst rpc", o_rpc, 32'd0);
        chk("mid_rst bcnt", o_bcnt, 32'd0);
        idle();
        cycle("after_rst");
        chk("after_rst redirect", {31'd0, o_redir}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 iClk  input  1  single clock; all state updates on rising edge.
REQ-002 iRst  input  1  reset, synchronous, active-high.
REQ-003 iValid  input  1  execute-stage instruction present this cycle.
REQ-004 iPc  input  32  PC of the executing instruction.
REQ-005 iImm  input  32  sign-extended immediate.
REQ-006 iAluResult  input  32  ALU oData for this instruction (rs1+imm for JALR).
REQ-007 iAluZero  input  1  ALU oZero; for branch control codes it is the branch-condition-true flag.
REQ-008 iRs2Data  input  32  store data.
REQ-009 iRdAddr  input  5  destination register.
REQ-010 iRegWrite, iMemRead, iMemWrite  input  1 each  control bits.
REQ-011 iIsBranch, iIsJal, iIsJalr  input  1 each  instruction class, at most one set.
REQ-012 iStall  input  1  memory stage not ready; hold stage.
REQ-013 oReady  output  1  equals !iStall.
REQ-014 oValid, oResult[32], oStoreData[32], oRdAddr[5], oRegWrite, oMemRead, oMemWrite  output  registered EX/MEM payload.
REQ-015 oRedirect  output  1  one-cycle PC-redirect pulse; oRedirectPc  output  32  target.
REQ-016 oExcMisalign  output  1  one-cycle pulse; oExcPc  output  32  faulting PC.
REQ-017 oBranchCnt, oTakenCnt  output  32 each  conditional-branch performance counters.

Function
REQ-018 Accept = iValid && !iStall && state==NORMAL; stage register loads only when !iStall.
REQ-019 When !iStall and not accept, stage register SHALL load a bubble (oValid=0, all control bits 0).
REQ-020 When iStall=1, all payload outputs and counters SHALL hold unchanged.
REQ-021 Taken = iIsJal || iIsJalr || (iIsBranch && iAluZero).
REQ-022 Target = iPc+iImm for branch/JAL; {iAluResult[31:1],1'b0} for JALR; 32-bit wrap-around.
REQ-023 oResult = iPc+4 for JAL/JALR, else iAluResult.
REQ-024 Taken with Target[1]=0 on accept: next cycle oRedirect=1, oRedirectPc=Target, for exactly one cycle.
REQ-025 Taken with Target[1]=1 on accept: next cycle oExcMisalign=1, oExcPc=iPc, no redirect; instruction captured with oValid=1 but oRegWrite/oMemRead/oMemWrite forced 0.
REQ-026 FSM states NORMAL, SHADOW; NORMAL->SHADOW on accept of a taken non-misaligned instruction; SHADOW->NORMAL unconditionally next cycle.
REQ-027 In SHADOW (the oRedirect cycle) any iValid is wrong-path: not captured, no redirect, no counter update; bubble loaded if !iStall.
REQ-028 Misaligned taken instruction SHALL NOT enter SHADOW.
REQ-029 oBranchCnt increments on every accepted iIsBranch; oTakenCnt additionally when taken; both wrap 0xFFFFFFFF->0; JAL/JALR not counted.
REQ-030 oRedirect/oExcMisalign pulses SHALL NOT be repeated or extended by iStall.

Reset
REQ-031 iRst=1 on a clock edge: state=NORMAL, oValid=0, all payload/control outputs 0, oRedirect=0, oRedirectPc=0, oExcMisalign=0, oExcPc=0, counters 0.
REQ-032 Reset overrides iStall and a pending redirect; a redirect scheduled for the cycle after reset SHALL be dropped.

Structure
REQ-033 Shared package rv_core_pkg holds FSM state encoding (NORMAL=0, SHADOW=1), PC_INC=4, XLEN=32.
REQ-034 One combinational sub-module branch_target_unit computes Taken, Target and misalign flag; register, FSM and counters remain in ex_mem_stage.

Verification
REQ-035 BEQ taken: iPc=0x100, iImm=0x20, iAluZero=1 -> next cycle oRedirect=1, oRedirectPc=0x120, oBranchCnt=1, oTakenCnt=1.
REQ-036 Shadow squash: instruction presented in the oRedirect cycle with iRegWrite=1 -> captured oValid=0, oRegWrite=0.
REQ-037 JALR misaligned: iAluResult=0x203, iPc=0x40 -> oExcMisalign=1, oExcPc=0x40, oRedirect=0, oRegWrite=0.
REQ-038 JAL link: iPc=0x80, iImm=0x10, iRdAddr=1 -> oResult=0x84, oRedirectPc=0x90.
REQ-039 Stall hold: iStall=1 for 3 cycles with changing inputs -> payload and counters unchanged, oReady=0.
REQ-040 Counter wrap and reset: oBranchCnt preloaded to 0xFFFFFFFF via 2^32-1 branches (or forced) -> next branch gives 0; iRst mid-redirect -> all outputs 0 next cycle.
